idea_c_checker: RTL and testbench

- Sequence checker and decoder at the consumer end of the IdeaC-style down-counter output bus (VAL).
- Watches the 4-bit value stream and confirms it follows the wrap-down sequence HI, HI-1, …, LO, HI, …
- Locks after LOCK_N consecutive correct steps, then reports errors, full-cycle wraps and the position within the cycle.
- Sits beside the counter. Also used standalone in benches as a self-check.

---
 rtl/idea_c_checker.sv | 125 ++++++++++++
 tb/tb_idea_c_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/idea_c_checker.sv
// Wrap-down sequence checker (HI..LO, HI..) that locks after LOCK_N good steps and then reports wraps/errors.
// All outputs are registered and reflect a STEP sample one cycle later; there is no backpressure, and STEP may assert every cycle.
module idea_c_checker #(
  parameter logic [3:0] LO     = 4'd5,
  parameter logic [3:0] HI     = 4'd14,
  parameter int         LOCK_N = 3,
  parameter int         CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STEP,
  input  logic [3:0]       VAL,
  output logic             LOCKED,
  output logic [3:0]       EXPECT,
  output logic [3:0]       PHASE,
  output logic             WRAP,
  output logic             ERR,
  output logic [CNT_W-1:0] WRAP_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {S_EMPTY, S_HUNT, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       last_q, last_d;
  logic             have_prev_q, have_prev_d;
  logic [2:0]       match_q, match_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             is_match;
  logic [2:0]       match_inc;

  // Out-of-range values recover to LO, so a stuck/garbage counter relocks cleanly.
  function automatic logic [3:0] nxt(input logic [3:0] x);
    if (x == LO)
      nxt = HI;
    else if (x > LO && x <= HI)
      nxt = x - 4'd1;
    else
      nxt = LO;
  endfunction

  assign is_match  = (VAL == nxt(last_q));
  assign match_inc = match_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (STEP) begin
      last_d = VAL;
      case (state_q)
        S_EMPTY: begin
          have_prev_d = 1'b1;
          state_d     = S_HUNT;
        end
        S_HUNT: begin
          if (is_match) begin
            if (match_inc == 3'(LOCK_N)) begin
              state_d = S_LOCKED;
              match_d = 3'd0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = 3'd0;
          end
        end
        S_LOCKED: begin
          if (is_match) begin
            if (last_q == LO && VAL == HI) begin
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
            match_d = 3'd0;
            if (err_cnt_q != {CNT_W{1'b1}})
              err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_EMPTY;
      last_q      <= 4'd0;
      have_prev_q <= 1'b0;
      match_q     <= 3'd0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      wrap_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign LOCKED   = (state_q == S_LOCKED);
  assign EXPECT   = have_prev_q ? nxt(last_q) : 4'd0;
  assign PHASE    = (last_q >= LO && last_q <= HI) ? (HI - last_q) : 4'd0;
  assign WRAP     = wrap_q;
  assign ERR      = err_q;
  assign WRAP_CNT = wrap_cnt_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_idea_c_checker.sv
// Scoreboard bench for idea_c_checker: stimulus queues hand-derived expectations, a monitor compares them a cycle later.
module tb_idea_c_checker;

  typedef struct packed {
    logic       l;
    logic [3:0] ex;
    logic [3:0] ph;
    logic       w;
    logic       e;
    logic [7:0] wc;
    logic [7:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [3:0] val;
  logic       locked, wrap, err;
  logic [3:0] expect_o, phase;
  logic [7:0] wrap_cnt, err_cnt;

  exp_t exp_q[$];
  int   due_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t hold;

  idea_c_checker #(.LO(4'd5), .HI(4'd14), .LOCK_N(3), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .STEP(step), .VAL(val),
    .LOCKED(locked), .EXPECT(expect_o), .PHASE(phase),
    .WRAP(wrap), .ERR(err), .WRAP_CNT(wrap_cnt), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every entry is due on the negedge following the edge that sampled its stimulus.
  always @(negedge clk) begin
    exp_t a, x;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      x = exp_q.pop_front();
      void'(due_q.pop_front());
      a = '{locked, expect_o, phase, wrap, err, wrap_cnt, err_cnt};
      vectors++;
      if (a !== x) begin
        miscompares++;
        $display("FAIL vec%0d @cyc%0d got L=%0b EX=%0d PH=%0d W=%0b E=%0b WC=%0d EC=%0d want L=%0b EX=%0d PH=%0d W=%0b E=%0b WC=%0d EC=%0d",
                 vectors, cyc, a.l, a.ex, a.ph, a.w, a.e, a.wc, a.ec,
                 x.l, x.ex, x.ph, x.w, x.e, x.wc, x.ec);
      end
    end
  end

  task automatic push(input exp_t x);
    exp_q.push_back(x);
    due_q.push_back(cyc + 1);
    hold = x;
    hold.w = 1'b0;
    hold.e = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b1; val = 4'd9;
    push('{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0});
    @(negedge clk);
    rst = 1'b0; step = 1'b0; val = 4'd0;
  endtask

  task automatic stp(input logic [3:0] v, input logic l, input logic [3:0] ex,
                     input logic [3:0] ph, input logic w, input logic e,
                     input logic [7:0] wc, input logic [7:0] ec);
    @(negedge clk);
    step = 1'b1; val = v;
    push('{l, ex, ph, w, e, wc, ec});
    @(negedge clk);
    step = 1'b0; val = 4'd0;
  endtask

  // Back-to-back variant: leaves STEP high so consecutive calls hit consecutive edges.
  task automatic stp_b2b(input logic [3:0] v, input logic l, input logic [3:0] ex,
                         input logic [3:0] ph, input logic w, input logic e,
                         input logic [7:0] wc, input logic [7:0] ec);
    @(negedge clk);
    step = 1'b1; val = v;
    push('{l, ex, ph, w, e, wc, ec});
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step = 1'b0; val = 4'd7;
      push(hold);
    end
  endtask

  initial begin
    int wait_cyc;
    logic [7:0] ec;
    logic [3:0] v;
    rst = 1'b1; step = 1'b0; val = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_reset();

    // Back-to-back lock on 14,13,12,11
    stp_b2b(14, 0, 13, 0, 0, 0, 0, 0);
    stp_b2b(13, 0, 12, 1, 0, 0, 0, 0);
    stp_b2b(12, 0, 11, 2, 0, 0, 0, 0);
    stp_b2b(11, 1, 10, 3, 0, 0, 0, 0);
    stp_b2b(10, 1,  9, 4, 0, 0, 0, 0);
    stp_b2b( 9, 1,  8, 5, 0, 0, 0, 0);
    stp_b2b( 8, 1,  7, 6, 0, 0, 0, 0);
    stp_b2b( 7, 1,  6, 7, 0, 0, 0, 0);
    stp_b2b( 6, 1,  5, 8, 0, 0, 0, 0);
    stp_b2b( 5, 1, 14, 9, 0, 0, 0, 0);
    stp_b2b(14, 1, 13, 0, 1, 0, 1, 0);
    stp_b2b(13, 1, 12, 1, 0, 0, 1, 0);
    gap(2);
    // Skip 12 -> error, then relock
    stp(11, 0, 10, 3, 0, 1, 1, 1);
    stp(10, 0,  9, 4, 0, 0, 1, 1);
    stp( 9, 0,  8, 5, 0, 0, 1, 1);
    stp( 8, 1,  7, 6, 0, 0, 1, 1);
    // Out-of-range while locked, then 15 -> 5 recovery; no wrap in HUNT
    stp(15, 0,  5, 0, 0, 1, 1, 2);
    stp( 5, 0, 14, 9, 0, 0, 1, 2);
    stp(14, 0, 13, 0, 0, 0, 1, 2);
    stp(13, 1, 12, 1, 0, 0, 1, 2);

    // Lock with gaps of 3 idle cycles
    do_reset();
    stp(9, 0, 8, 5, 0, 0, 0, 0); gap(3);
    stp(8, 0, 7, 6, 0, 0, 0, 0); gap(3);
    stp(7, 0, 6, 7, 0, 0, 0, 0); gap(3);
    stp(6, 1, 5, 8, 0, 0, 0, 0); gap(3);

    // Mid-stream reset; first step only primes
    do_reset();
    stp( 3, 0,  5, 0, 0, 0, 0, 0);
    stp( 7, 0,  6, 7, 0, 0, 0, 0);
    stp( 6, 0,  5, 8, 0, 0, 0, 0);
    stp( 5, 0, 14, 9, 0, 0, 0, 0);
    stp(14, 1, 13, 0, 0, 0, 0, 0);

    // 300 forced errors with relock; count saturates at 255
    for (int i = 1; i <= 300; i++) begin
      ec = (i > 255) ? 8'd255 : 8'(i);
      stp_b2b( 0, 0,  5, 0, 0, 1, 0, ec);
      stp_b2b( 5, 0, 14, 9, 0, 0, 0, ec);
      stp_b2b(14, 0, 13, 0, 0, 0, 0, ec);
      stp_b2b(13, 1, 12, 1, 0, 0, 0, ec);
    end

    // 260 full cycles; wrap count rolls over to 4
    for (int i = 1; i <= 260; i++) begin
      for (int k = 0; k < 8; k++) begin
        v = 4'(12 - k);
        stp_b2b(v, 1, (v == 4'd5) ? 4'd14 : v - 4'd1, 4'd14 - v, 0, 0, 8'(i - 1), 8'd255);
      end
      stp_b2b(14, 1, 13, 0, 1, 0, 8'(i), 8'd255);
      stp_b2b(13, 1, 12, 1, 0, 0, 8'(i), 8'd255);
    end
    @(negedge clk);
    step = 1'b0;

    wait_cyc = 0;
    while (due_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (due_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", due_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
